// File: rtl/reorder_buffer.sv
// In-order-retirement reorder buffer: circular entry array with multi-port completion,
// head-driven commit/store/flush outputs and youngest-producer dependency lookup.
module reorder_buffer #(
  parameter int REGISTER_SIZE    = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int ADDRESS_SIZE     = 32,
  parameter int ID_SIZE          = 3,
  parameter int N_PORTS          = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_req,
  input  logic [REG_ADDRESS_SIZE-1:0]       alloc_dest,
  input  logic                              alloc_is_store,
  output logic [ID_SIZE-1:0]                alloc_id,
  output logic                              alloc_stall,
  input  logic [N_PORTS-1:0]                cpl_valid,
  input  logic [N_PORTS*ID_SIZE-1:0]        cpl_id,
  input  logic [N_PORTS*REGISTER_SIZE-1:0]  cpl_data,
  input  logic [N_PORTS*ADDRESS_SIZE-1:0]   cpl_address,
  input  logic [N_PORTS-1:0]                cpl_exc,
  input  logic [REG_ADDRESS_SIZE-1:0]       dep_addr1,
  input  logic [REG_ADDRESS_SIZE-1:0]       dep_addr2,
  output logic                              dep_hit1,
  output logic                              dep_hit2,
  output logic                              dep_ready1,
  output logic                              dep_ready2,
  output logic [ID_SIZE-1:0]                dep_id1,
  output logic [ID_SIZE-1:0]                dep_id2,
  output logic [REGISTER_SIZE-1:0]          dep_value1,
  output logic [REGISTER_SIZE-1:0]          dep_value2,
  output logic                              commit_we,
  output logic [REG_ADDRESS_SIZE-1:0]       commit_addr,
  output logic [REGISTER_SIZE-1:0]          commit_data,
  output logic                              store_req,
  output logic [ADDRESS_SIZE-1:0]           store_address,
  output logic [REGISTER_SIZE-1:0]          store_data,
  input  logic                              store_stall,
  output logic                              flush,
  output logic [ID_SIZE-1:0]                flush_id,
  output logic                              empty
);

  localparam int DEPTH = 1 << ID_SIZE;
  localparam logic [ID_SIZE:0] FULL_CNT = (ID_SIZE+1)'(DEPTH);

  logic [ID_SIZE-1:0]          head_q, head_d, tail_q, tail_d;
  logic [ID_SIZE:0]            count_q, count_d;
  logic [DEPTH-1:0]            alloc_q, alloc_d, done_q, done_d, exc_q, exc_d, st_q, st_d;
  logic [REG_ADDRESS_SIZE-1:0] dest_q [DEPTH];
  logic [REG_ADDRESS_SIZE-1:0] dest_d [DEPTH];
  logic [REGISTER_SIZE-1:0]    data_q [DEPTH];
  logic [REGISTER_SIZE-1:0]    data_d [DEPTH];
  logic [ADDRESS_SIZE-1:0]     addr_q [DEPTH];
  logic [ADDRESS_SIZE-1:0]     addr_d [DEPTH];

  logic               head_rdy, do_retire, do_alloc;
  logic [ID_SIZE-1:0] cpl_idx;

  assign head_rdy      = alloc_q[head_q] & done_q[head_q];
  assign flush         = head_rdy & exc_q[head_q];
  assign flush_id      = head_q;
  assign store_req     = head_rdy & ~exc_q[head_q] & st_q[head_q];
  assign commit_we     = head_rdy & ~exc_q[head_q] & ~st_q[head_q] & (dest_q[head_q] != '0);
  assign commit_addr   = dest_q[head_q];
  assign commit_data   = data_q[head_q];
  assign store_address = addr_q[head_q];
  assign store_data    = data_q[head_q];
  assign do_retire     = head_rdy & ~exc_q[head_q] & (~st_q[head_q] | ~store_stall);
  assign alloc_stall   = (count_q == FULL_CNT) | flush;
  assign do_alloc      = alloc_req & ~alloc_stall;
  assign alloc_id      = tail_q;
  assign empty         = (count_q == '0);

  // Allocated entries form one contiguous run starting at head, so the last match
  // found walking forward from head is the youngest producer.
  function automatic logic [ID_SIZE:0] find_dep(input logic [REG_ADDRESS_SIZE-1:0] a);
    logic [ID_SIZE:0]   r;
    logic [ID_SIZE-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + ID_SIZE'(i);
      if (alloc_q[idx] && !st_q[idx] && (dest_q[idx] == a) && (a != '0))
        r = {1'b1, idx};
    end
    return r;
  endfunction

  assign {dep_hit1, dep_id1} = find_dep(dep_addr1);
  assign {dep_hit2, dep_id2} = find_dep(dep_addr2);
  assign dep_ready1 = done_q[dep_id1];
  assign dep_ready2 = done_q[dep_id2];
  assign dep_value1 = data_q[dep_id1];
  assign dep_value2 = data_q[dep_id2];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    alloc_d = alloc_q;
    done_d  = done_q;
    exc_d   = exc_q;
    st_d    = st_q;
    dest_d  = dest_q;
    data_d  = data_q;
    addr_d  = addr_q;
    cpl_idx = '0;
    // Highest port first so a lower-indexed port writing the same id overrides it.
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      cpl_idx = cpl_id[p*ID_SIZE +: ID_SIZE];
      if (cpl_valid[p] && alloc_q[cpl_idx]) begin
        data_d[cpl_idx] = cpl_data[p*REGISTER_SIZE +: REGISTER_SIZE];
        addr_d[cpl_idx] = cpl_address[p*ADDRESS_SIZE +: ADDRESS_SIZE];
        exc_d[cpl_idx]  = cpl_exc[p];
        done_d[cpl_idx] = 1'b1;
      end
    end
    if (do_retire) begin
      alloc_d[head_q] = 1'b0;
      head_d          = head_q + ID_SIZE'(1);
    end
    if (do_alloc) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      exc_d[tail_q]   = 1'b0;
      st_d[tail_q]    = alloc_is_store;
      dest_d[tail_q]  = alloc_dest;
      tail_d          = tail_q + ID_SIZE'(1);
    end
    count_d = count_q + (ID_SIZE+1)'(do_alloc) - (ID_SIZE+1)'(do_retire);
    if (flush) begin
      alloc_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      st_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      st_q    <= st_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: ordered-queue model checked every negedge, plus directed literal checks.
module tb_reorder_buffer;
  localparam int RS = 32, RA = 5, AS = 32, IDS = 3, NP = 3, DEPTH = 8;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic              reset, alloc_req, alloc_is_store, alloc_stall, store_stall;
  logic [RA-1:0]     alloc_dest, dep_addr1, dep_addr2, commit_addr;
  logic [IDS-1:0]    alloc_id, dep_id1, dep_id2, flush_id;
  logic [NP-1:0]     cpl_valid, cpl_exc;
  logic [NP*IDS-1:0] cpl_id;
  logic [NP*RS-1:0]  cpl_data;
  logic [NP*AS-1:0]  cpl_address;
  logic              dep_hit1, dep_hit2, dep_ready1, dep_ready2;
  logic [RS-1:0]     dep_value1, dep_value2, commit_data, store_data;
  logic [AS-1:0]     store_address;
  logic              commit_we, store_req, flush, empty;

  reorder_buffer #(.REGISTER_SIZE(RS), .REG_ADDRESS_SIZE(RA), .ADDRESS_SIZE(AS),
                   .ID_SIZE(IDS), .N_PORTS(NP)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_dest(alloc_dest),
    .alloc_is_store(alloc_is_store), .alloc_id(alloc_id), .alloc_stall(alloc_stall),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_data(cpl_data), .cpl_address(cpl_address),
    .cpl_exc(cpl_exc), .dep_addr1(dep_addr1), .dep_addr2(dep_addr2),
    .dep_hit1(dep_hit1), .dep_hit2(dep_hit2), .dep_ready1(dep_ready1), .dep_ready2(dep_ready2),
    .dep_id1(dep_id1), .dep_id2(dep_id2), .dep_value1(dep_value1), .dep_value2(dep_value2),
    .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data),
    .store_req(store_req), .store_address(store_address), .store_data(store_data),
    .store_stall(store_stall), .flush(flush), .flush_id(flush_id), .empty(empty)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-flight entries in program order, oldest at index 0.
  typedef struct {
    int          id;
    int          dest;
    bit          st;
    bit          done;
    bit          exc;
    logic [31:0] data;
    logic [31:0] addr;
  } ent_t;

  ent_t q[$];
  int   tail_m = 0;

  function automatic void mdep(input int a, output bit hit, output int id, output bit rdy,
                               output logic [31:0] val);
    hit = 0; id = 0; rdy = 0; val = '0;
    if (a != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!q[i].st && q[i].dest == a) begin
          hit = 1; id = q[i].id; rdy = q[i].done; val = q[i].data;
          break;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    bit          rdy, e_flush, e_store, e_commit, full, retire, h;
    bit [7:0]    written;
    int          id, cid;
    bit          r;
    logic [31:0] v;
    ent_t        e;
    full     = (q.size() == DEPTH);
    rdy      = (q.size() > 0) && q[0].done;
    e_flush  = rdy && q[0].exc;
    e_store  = rdy && !q[0].exc && q[0].st;
    e_commit = rdy && !q[0].exc && !q[0].st && (q[0].dest != 0);
    retire   = rdy && !q[0].exc && (!q[0].st || !store_stall);

    chk("m_alloc_stall", alloc_stall, full || e_flush);
    chk("m_alloc_id", alloc_id, tail_m);
    chk("m_empty", empty, q.size() == 0);
    chk("m_flush", flush, e_flush);
    chk("m_store_req", store_req, e_store);
    chk("m_commit_we", commit_we, e_commit);
    if (e_flush) chk("m_flush_id", flush_id, q[0].id);
    if (e_store) begin
      chk("m_store_address", store_address, q[0].addr);
      chk("m_store_data", store_data, q[0].data);
    end
    if (e_commit) begin
      chk("m_commit_addr", commit_addr, q[0].dest);
      chk("m_commit_data", commit_data, q[0].data);
    end
    mdep(int'(dep_addr1), h, id, r, v);
    chk("m_dep_hit1", dep_hit1, h);
    if (h) begin
      chk("m_dep_id1", dep_id1, id);
      chk("m_dep_ready1", dep_ready1, r);
      if (r) chk("m_dep_value1", dep_value1, v);
    end
    mdep(int'(dep_addr2), h, id, r, v);
    chk("m_dep_hit2", dep_hit2, h);
    if (h) begin
      chk("m_dep_id2", dep_id2, id);
      chk("m_dep_ready2", dep_ready2, r);
      if (r) chk("m_dep_value2", dep_value2, v);
    end

    // Advance the model by what the coming rising edge does.
    if (!reset || e_flush) begin
      q.delete();
      tail_m = 0;
    end else begin
      written = '0;
      for (int p = 0; p < NP; p++) begin
        if (cpl_valid[p]) begin
          cid = int'(cpl_id[p*IDS +: IDS]);
          if (!written[cid]) begin
            for (int i = 0; i < q.size(); i++) begin
              if (q[i].id == cid) begin
                e = q[i];
                e.done = 1; e.exc = cpl_exc[p];
                e.data = cpl_data[p*RS +: RS];
                e.addr = cpl_address[p*AS +: AS];
                q[i] = e;
                written[cid] = 1'b1;
              end
            end
          end
        end
      end
      if (retire) void'(q.pop_front());
      if (alloc_req && !full) begin
        e.id = tail_m; e.dest = int'(alloc_dest); e.st = alloc_is_store;
        e.done = 0; e.exc = 0; e.data = '0; e.addr = '0;
        q.push_back(e);
        tail_m = (tail_m + 1) % DEPTH;
      end
    end
  end

  task automatic idle();
    alloc_req = 0; alloc_dest = '0; alloc_is_store = 0;
    cpl_valid = '0; cpl_id = '0; cpl_data = '0; cpl_address = '0; cpl_exc = '0;
    store_stall = 0; dep_addr1 = '0; dep_addr2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_one(input int dest, input bit st);
    idle();
    alloc_req = 1; alloc_dest = RA'(dest); alloc_is_store = st;
    tick();
  endtask

  task automatic cpl(input int p, input int id, input logic [31:0] d, input logic [31:0] a,
                     input bit x);
    cpl_valid[p] = 1'b1;
    cpl_id[p*IDS +: IDS] = IDS'(id);
    cpl_data[p*RS +: RS] = d;
    cpl_address[p*AS +: AS] = a;
    cpl_exc[p] = x;
  endtask

  initial begin
    idle();
    reset = 0;
    tick(); tick();
    reset = 1; dep_addr1 = 5'd1;
    #1;
    chk("rst_empty", empty, 1); chk("rst_alloc_id", alloc_id, 0);
    chk("rst_alloc_stall", alloc_stall, 0); chk("rst_commit_we", commit_we, 0);
    chk("rst_store_req", store_req, 0); chk("rst_flush", flush, 0);
    chk("rst_dep_hit1", dep_hit1, 0);

    // Fill all eight entries with dest 1..8.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); alloc_req = 1; alloc_dest = RA'(i + 1);
      #1;
      chk("fill_alloc_id", alloc_id, i);
      chk("fill_alloc_stall", alloc_stall, 0);
      tick();
    end
    idle(); alloc_req = 1; alloc_dest = 5'd9;
    #1;
    chk("full_stall", alloc_stall, 1); chk("full_empty", empty, 0); chk("full_alloc_id", alloc_id, 0);

    // Out-of-order completion on all ports at once; retire must stay in order.
    cpl(0, 2, 32'h20, 32'h0, 0); cpl(1, 0, 32'h00, 32'h0, 0); cpl(2, 1, 32'h10, 32'h0, 0);
    tick();
    idle(); alloc_req = 1; alloc_dest = 5'd9;
    #1;
    chk("ret0_we", commit_we, 1); chk("ret0_addr", commit_addr, 1); chk("ret0_data", commit_data, 0);
    chk("ret0_full_stall", alloc_stall, 1);
    tick(); idle(); #1;
    chk("ret1_we", commit_we, 1); chk("ret1_addr", commit_addr, 2); chk("ret1_data", commit_data, 32'h10);
    tick(); idle(); #1;
    chk("ret2_we", commit_we, 1); chk("ret2_addr", commit_addr, 3); chk("ret2_data", commit_data, 32'h20);
    tick(); idle(); #1;
    chk("ret3_we", commit_we, 0);

    // Exception on id 3: flush, with same-cycle alloc and completion discarded.
    cpl(1, 3, 32'hDEAD, 32'h0, 1);
    tick();
    idle(); alloc_req = 1; alloc_dest = 5'd4; cpl(0, 4, 32'h4, 32'h0, 0);
    #1;
    chk("exc_flush", flush, 1); chk("exc_flush_id", flush_id, 3);
    chk("exc_commit_we", commit_we, 0); chk("exc_alloc_stall", alloc_stall, 1);
    tick(); idle(); #1;
    chk("postflush_empty", empty, 1); chk("postflush_alloc_id", alloc_id, 0);
    chk("postflush_flush", flush, 0);

    // Store held at head while the store path stalls.
    alloc_one(0, 1);
    idle(); cpl(0, 0, 32'hABCD, 32'h1000, 0); store_stall = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(); store_stall = 1;
      #1;
      chk("st_hold_req", store_req, 1); chk("st_hold_addr", store_address, 32'h1000);
      chk("st_hold_data", store_data, 32'hABCD); chk("st_hold_empty", empty, 0);
      chk("st_hold_we", commit_we, 0);
      tick();
    end
    idle(); #1;
    chk("st_go_req", store_req, 1);
    tick(); idle(); #1;
    chk("st_done_empty", empty, 1); chk("st_done_req", store_req, 0);

    // Two writers of r5 (ids 1 and 4) with a store targeting r5 between them.
    alloc_one(5, 0); alloc_one(6, 0); alloc_one(5, 1); alloc_one(5, 0);
    idle(); cpl(2, 1, 32'h55, 32'h0, 0);
    tick();
    idle(); dep_addr1 = 5'd5; dep_addr2 = 5'd6;
    #1;
    chk("dep_hit1", dep_hit1, 1); chk("dep_id1", dep_id1, 4); chk("dep_ready1", dep_ready1, 0);
    chk("dep_hit2", dep_hit2, 1); chk("dep_id2", dep_id2, 2); chk("dep_ready2", dep_ready2, 0);
    chk("dep_commit_addr", commit_addr, 5); chk("dep_commit_data", commit_data, 32'h55);
    dep_addr2 = 5'd0;
    #1;
    chk("dep_zero_hit", dep_hit2, 0);
    tick();
    idle(); cpl(0, 4, 32'h44, 32'h0, 0); dep_addr1 = 5'd5;
    #1;
    chk("dep_nofwd_ready", dep_ready1, 0);
    tick();
    idle(); dep_addr1 = 5'd5;
    #1;
    chk("dep_rdy_hit", dep_hit1, 1); chk("dep_rdy_id", dep_id1, 4);
    chk("dep_rdy_ready", dep_ready1, 1); chk("dep_rdy_value", dep_value1, 32'h44);

    // Reset with five entries in flight.
    alloc_one(1, 0); alloc_one(2, 0);
    idle(); dep_addr1 = 5'd2; #1;
    chk("pre_rst_hit", dep_hit1, 1);
    reset = 0;
    tick(); idle(); dep_addr1 = 5'd2; #1;
    chk("mid_rst_empty", empty, 1); chk("mid_rst_alloc_id", alloc_id, 0);
    chk("mid_rst_stall", alloc_stall, 0); chk("mid_rst_we", commit_we, 0);
    chk("mid_rst_store", store_req, 0); chk("mid_rst_flush", flush, 0);
    chk("mid_rst_hit", dep_hit1, 0);
    reset = 1;

    // Mixed traffic exercising wrap, full, stalls, flushes and ignored completions.
    for (int c = 0; c < 600; c++) begin
      idle();
      alloc_req      = ($urandom_range(0, 3) != 0);
      alloc_dest     = RA'($urandom_range(0, 7));
      alloc_is_store = ($urandom_range(0, 4) == 0);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0)
          cpl(p, int'($urandom_range(0, DEPTH - 1)), $urandom, $urandom, $urandom_range(0, 40) == 0);
      end
      store_stall = ($urandom_range(0, 2) == 0);
      dep_addr1   = RA'($urandom_range(0, 7));
      dep_addr2   = RA'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order-retirement reorder buffer for the out-of-order core, sitting between issue/rename (allocation), the functional units and LSU (completion), and the register file and store path (retirement). Generalises the single-retire ROB: configurable depth and completion-port count, all completion ports write in the same cycle without arbitration, explicit allocation handshake with full/empty tracking, and precise-exception flush. Two combinational dependency-lookup ports return the youngest in-flight producer of a register for operand bypass.

## Interface
- REGISTER_SIZE, 32, data width
- REG_ADDRESS_SIZE, 5, architectural register index width
- ADDRESS_SIZE, 32, store address width
- ID_SIZE, 3, entry index width; DEPTH = 1<<ID_SIZE
- N_PORTS, 3, completion ports

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge)
- alloc_req  in  1  issue requests one entry
- alloc_dest  in  REG_ADDRESS_SIZE  destination register (0 = no register write)
- alloc_is_store  in  1  entry is a store
- alloc_id  out  ID_SIZE  id granted (= tail)
- alloc_stall  out  1  allocation refused this cycle
- cpl_valid  in  N_PORTS  per-port completion strobe
- cpl_id  in  N_PORTS*ID_SIZE  entry id, port p at bits [p*ID_SIZE +: ID_SIZE]
- cpl_data  in  N_PORTS*REGISTER_SIZE  result / store data
- cpl_address  in  N_PORTS*ADDRESS_SIZE  store address (ignored for non-stores)
- cpl_exc  in  N_PORTS  completion raised an exception
- dep_addr1, dep_addr2  in  REG_ADDRESS_SIZE  lookup register
- dep_hit1/2  out  1  an allocated non-store entry targets the register
- dep_ready1/2  out  1  that entry has completed
- dep_id1/2  out  ID_SIZE  that entry's id
- dep_value1/2  out  REGISTER_SIZE  that entry's data (valid when ready)
- commit_we  out  1  retire writes the register file this cycle
- commit_addr  out  REG_ADDRESS_SIZE ; commit_data  out  REGISTER_SIZE
- store_req  out  1 ; store_address  out  ADDRESS_SIZE ; store_data  out  REGISTER_SIZE
- store_stall  in  1  store path cannot accept
- flush  out  1  exception retiring, pipeline must squash
- flush_id  out  ID_SIZE  id of the faulting entry
- empty  out  1  count == 0

## Operation
- State: head, tail (ID_SIZE, wrap modulo DEPTH), count (ID_SIZE+1 bits); per entry: alloc, done, exc, is_store, dest, data, address.
- Allocation: alloc_stall = (count == DEPTH) | flush. On alloc_req & !alloc_stall: entry[tail] gets alloc=1, done=0, exc=0, dest, is_store; tail+1.
- Completion: each port p with cpl_valid[p] whose target entry has alloc=1 writes data, address, exc and sets done. Completions to unallocated entries are ignored. Two ports with same id same cycle: lowest port index wins.
- Head is retirable when alloc & done. Combinational outputs from head:
  - exc=1: flush=1, flush_id=head, commit_we=0, store_req=0.
  - store: store_req=1, retires only if !store_stall.
  - otherwise: commit_we = (dest != 0), retires unconditionally.
- Retire: clear alloc at head, head+1, count-1. Count updates by +alloc-retire (simultaneous alloc and retire leaves count unchanged).
- Flush edge: all alloc bits cleared, head=tail=0, count=0; same-cycle allocation and completions discarded.
- Lookup: youngest (closest to tail) entry with alloc & !is_store & dest==dep_addr; dep_addr==0 never hits. Same-cycle completions are not forwarded.

## Timing
- Reset values: head=tail=count=0, all alloc/done/exc=0; alloc_id=0, alloc_stall=0, empty=1, commit_we=0, store_req=0, flush=0, dep_hit*=0.
- Alloc at edge k; earliest completion edge k+1; retire outputs visible in following cycle; retires at edge k+2.
- Retire throughput: one entry per cycle; store held at head while store_stall=1, outputs stable.
- Full: allocation refused even if head retires that cycle.
- Reset has priority over flush, alloc, completion and retire; reset mid-operation discards all entries at that edge.
- Wrap: tail DEPTH-1 -> 0; full distinguished from empty by count only.

## Test plan
- Reset, then allocate 8 (DEPTH 8) entries dest 1..8 -> alloc_id 0..7, alloc_stall=1 after 8th, empty=0.
- Complete ids 2,0,1 on ports 0,1,2 in one cycle with data 0x20,0x00,0x10 -> retires ids 0,1,2 on three consecutive cycles, commit_addr 1,2,3, data in order.
- Store at head, store_stall=1 for 3 cycles -> store_req held, head unchanged; retires on first cycle store_stall=0.
- Entry 3 completes with cpl_exc=1 -> entries 0..2 retire, then flush=1, flush_id=3, next cycle empty=1, alloc_id=0, no commit for 3.
- Two in-flight writers of r5 (ids 1 then 4, only 1 done) -> dep_hit=1, dep_id=4, dep_ready=0; dep_addr=0 -> dep_hit=0.
- Assert reset=0 with 5 entries in flight -> next cycle empty=1, all outputs at reset values.
